// File: rtl/processor_nbit.sv
// Parametrised memory-ALU processor: INIT/FETCH/EXECUTE/STORE sequencing of
// immediate instructions against an internal register file. Optional PROC_SHIFT_EN enables SHL on opcode 111.
module processor_nbit #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [3+ADDR_W+DATA_W-1:0]  instruction,
    output logic [DATA_W-1:0]           result,
    output logic [DATA_W-1:0]           mem_out,
    output logic [1:0]                  current_state,
    output logic                        done,
    output logic                        carry,
    output logic                        zero
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_STORE = 2'b11
    } state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] imm;
    } instr_t;

    state_t                        state, state_nxt;
    instr_t                        ir;
    logic [DEPTH-1:0][DATA_W-1:0]  mem;
    logic [DATA_W-1:0]             rd;
    logic [DATA_W-1:0]             alu_res;
    logic                          alu_c;
    logic                          alu_upd;
    logic                          op_wr;
    logic                          accept;

    assign accept = (state == S_FETCH) && instr_valid;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_FETCH;
            S_FETCH: if (instr_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_STORE;
            S_STORE: state_nxt = S_FETCH;
            default: state_nxt = S_INIT;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        instr_ready   = (state == S_FETCH);
        done          = (state == S_STORE);
        current_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    ir <= '0;
        else if (accept) ir <= instruction;
    end

    assign rd = mem[ir.addr];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_upd = 1'b1;
        case (ir.op)
            3'b000: alu_res = ir.imm;
            3'b001: {alu_c, alu_res} = {1'b0, rd} + {1'b0, ir.imm};
            3'b010: begin
                alu_res = rd - ir.imm;
                alu_c   = (ir.imm > rd);
            end
            3'b011: alu_res = rd & ir.imm;
            3'b100: alu_res = rd | ir.imm;
            3'b101: alu_res = rd ^ ir.imm;
            3'b110: alu_res = ~rd;
            default: begin
`ifdef PROC_SHIFT_EN
                // Bit DATA_W of the widened shift is exactly the last bit shifted out
                logic [DATA_W:0] sh;
                sh      = {1'b0, rd} << ir.imm;
                alu_res = sh[DATA_W-1:0];
                alu_c   = sh[DATA_W];
`else
                alu_upd = 1'b0;
`endif
            end
        endcase
    end

`ifdef PROC_SHIFT_EN
    assign op_wr = 1'b1;
`else
    assign op_wr = (ir.op != 3'b111);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result  <= '0;
            mem_out <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else if (state == S_EXEC && alu_upd) begin
            result  <= alu_res;
            mem_out <= rd;
            carry   <= alu_c;
            zero    <= (alu_res == '0);
        end
    end

    // Write lands on the edge that ends STORE, so the next EXECUTE sees it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        mem          <= '0;
        else if (state == S_STORE && op_wr)  mem[ir.addr] <= result;
    end

endmodule

// File: tb/tb_processor_nbit.sv
// Directed bench for processor_nbit: a DATA_W=4/ADDR_W=4 instance and a
// DATA_W=8/ADDR_W=5 instance driven from one linear initial block.
module tb_processor_nbit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, vld4, rdy4, dn4, c4, z4;
    logic [10:0] ins4;
    logic [3:0]  res4, mo4;
    logic [1:0]  st4;

    logic        rst8, vld8, rdy8, dn8, c8, z8;
    logic [15:0] ins8;
    logic [7:0]  res8, mo8;
    logic [1:0]  st8;

    int checks = 0;
    int errors = 0;

    processor_nbit #(.DATA_W(4), .ADDR_W(4)) dut4 (
        .clk(clk), .reset_n(rst4), .instr_valid(vld4), .instr_ready(rdy4),
        .instruction(ins4), .result(res4), .mem_out(mo4), .current_state(st4),
        .done(dn4), .carry(c4), .zero(z4)
    );

    processor_nbit #(.DATA_W(8), .ADDR_W(5)) dut8 (
        .clk(clk), .reset_n(rst8), .instr_valid(vld8), .instr_ready(rdy8),
        .instruction(ins8), .result(res8), .mem_out(mo8), .current_state(st8),
        .done(dn8), .carry(c8), .zero(z8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction from a FETCH negedge; returns at the FETCH negedge after STORE
    task automatic run4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] imm);
        int n;
        n = 0;
        while (!rdy4 && n < 10) begin @(negedge clk); n++; end
        check("rdy4_wait", rdy4, 1);
        vld4 = 1'b1;
        ins4 = {op, a, imm};
        @(negedge clk);
        vld4 = 1'b0;
        @(negedge clk);
        check("done4", dn4, 1);
        @(negedge clk);
        check("done4_pulse", dn4, 0);
    endtask

    task automatic run8(input logic [2:0] op, input logic [4:0] a, input logic [7:0] imm);
        int n;
        n = 0;
        while (!rdy8 && n < 10) begin @(negedge clk); n++; end
        check("rdy8_wait", rdy8, 1);
        vld8 = 1'b1;
        ins8 = {op, a, imm};
        @(negedge clk);
        vld8 = 1'b0;
        @(negedge clk);
        check("done8", dn8, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] prog [3];
        int dc [3];
        int nd, nx, k;

        rst4 = 1'b0; vld4 = 1'b0; ins4 = '0;
        rst8 = 1'b0; vld8 = 1'b0; ins8 = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_state", st4, 0);
        check("rst_ready", rdy4, 0);
        check("rst_result", res4, 0);
        check("rst_memout", mo4, 0);
        check("rst_done", dn4, 0);
        check("rst_carry", c4, 0);
        check("rst_zero", z4, 0);
        rst4 = 1'b1; rst8 = 1'b1;
        check("init_state", st4, 0);
        check("init_ready", rdy4, 0);
        @(negedge clk);
        check("fetch_state", st4, 1);
        check("fetch_ready", rdy4, 1);
        check("fetch_state8", st8, 1);
        check("idle_result", res4, 0);

        // Arithmetic sequence
        run4(3'b000, 4'd0, 4'd5);
        check("sto_res", res4, 5);
        check("sto_mo", mo4, 0);
        run4(3'b001, 4'd0, 4'd3);
        check("add_res", res4, 8);
        check("add_mo", mo4, 5);
        check("add_c", c4, 0);
        run4(3'b010, 4'd0, 4'd2);
        check("sub_res", res4, 6);
        check("sub_c", c4, 0);
        run4(3'b001, 4'd0, 4'd0);
        check("add0_res", res4, 6);
        check("add0_mo", mo4, 6);
        run4(3'b000, 4'd2, 4'd1);
        run4(3'b001, 4'd2, 4'd15);
        check("wrap_res", res4, 0);
        check("wrap_c", c4, 1);
        check("wrap_z", z4, 1);

        // Logic sequence and borrow
        run4(3'b000, 4'd1, 4'd12);
        check("sto12_c", c4, 0);
        check("sto12_z", z4, 0);
        run4(3'b011, 4'd1, 4'd7);
        check("and_res", res4, 4);
        run4(3'b100, 4'd1, 4'd8);
        check("or_res", res4, 12);
        run4(3'b101, 4'd1, 4'd15);
        check("xor_res", res4, 3);
        run4(3'b110, 4'd1, 4'd9);
        check("not_res", res4, 12);
        run4(3'b010, 4'd1, 4'd13);
        check("borrow_res", res4, 15);
        check("borrow_c", c4, 1);
        check("borrow_mo", mo4, 12);

`ifdef PROC_SHIFT_EN
        run4(3'b000, 4'd3, 4'd11);
        run4(3'b111, 4'd3, 4'd1);
        check("shl1_res", res4, 6);
        check("shl1_c", c4, 1);
        check("shl1_z", z4, 0);
        run4(3'b000, 4'd3, 4'd11);
        run4(3'b111, 4'd3, 4'd4);
        check("shl4_res", res4, 0);
        check("shl4_c", c4, 1);
        check("shl4_z", z4, 1);
        run4(3'b001, 4'd3, 4'd0);
        check("shl4_mem", mo4, 0);
`else
        run4(3'b111, 4'd1, 4'd1);
        check("nop_res", res4, 15);
        check("nop_mo", mo4, 12);
        check("nop_c", c4, 1);
        check("nop_z", z4, 0);
        run4(3'b001, 4'd1, 4'd0);
        check("nop_mem", mo4, 15);
`endif

        // Back-to-back with instr_valid held high
        prog[0] = {3'b000, 4'd4, 4'd1};
        prog[1] = {3'b001, 4'd4, 4'd2};
        prog[2] = {3'b001, 4'd4, 4'd3};
        k = 0; nd = 0; nx = 0;
        vld4 = 1'b1; ins4 = prog[0];
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (dn4) begin
                if (nd < 3) dc[nd] = cyc;
                nd++;
            end
            if (st4 == 2'b10) begin
                nx++; k++;
                if (k < 3) ins4 = prog[k];
                else       vld4 = 1'b0;
            end
        end
        check("hs_dones", nd, 3);
        check("hs_execs", nx, 3);
        check("hs_gap01", dc[1] - dc[0], 3);
        check("hs_gap12", dc[2] - dc[1], 3);
        check("hs_res", res4, 6);
        check("hs_mo", mo4, 3);

        // instr_valid toggled outside FETCH must be ignored
        vld4 = 1'b1; ins4 = {3'b000, 4'd5, 4'd9};
        @(negedge clk);
        check("tg_exec", st4, 2);
        ins4 = {3'b000, 4'd5, 4'd3};
        @(negedge clk);
        check("tg_store", st4, 3);
        vld4 = 1'b0;
        @(negedge clk);
        check("tg_fetch", st4, 1);
        repeat (2) @(negedge clk);
        check("tg_idle", st4, 1);
        check("tg_res", res4, 9);
        run4(3'b001, 4'd5, 4'd0);
        check("tg_mem", mo4, 9);

        // Wide instance, reset mid-operation
        run8(3'b000, 5'd31, 8'd200);
        check("w_sto", res8, 200);
        run8(3'b001, 5'd31, 8'd100);
        check("w_add_res", res8, 44);
        check("w_add_c", c8, 1);
        check("w_add_mo", mo8, 200);
        vld8 = 1'b1; ins8 = {3'b001, 5'd31, 8'd5};
        @(negedge clk);
        vld8 = 1'b0;
        check("w_exec", st8, 2);
        rst8 = 1'b0;
        #1;
        check("w_rst_state", st8, 0);
        check("w_rst_ready", rdy8, 0);
        check("w_rst_res", res8, 0);
        check("w_rst_mo", mo8, 0);
        check("w_rst_c", c8, 0);
        check("w_rst_done", dn8, 0);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        run8(3'b001, 5'd31, 8'd0);
        check("w_post_res", res8, 0);
        check("w_post_mo", mo8, 0);
        check("w_post_c", c8, 0);
        check("w_post_z", z8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
